// File: rtl/dsp_pkg.sv
// Shared definitions for the receive-chain DSP stages.
//
// FIR_ACC_W / SAMPLE_W     : FIR accumulator width (Q2.30) and output sample width (Q1.15)
// FIR_FRAC / SAMPLE_FRAC   : fractional bit counts of those formats
// SAT_MAX / SAT_MIN        : Q1.15 clamp values
// requant_t                : requantised sample plus a flag telling whether it clamped
package dsp_pkg;

    localparam int FIR_ACC_W   = 32;
    localparam int SAMPLE_W    = 16;
    localparam int FIR_FRAC    = 30;
    localparam int SAMPLE_FRAC = 15;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

    typedef struct packed {
        logic                sat;
        logic [SAMPLE_W-1:0] data;
    } requant_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer with fully registered outputs.
//
// clk, reset      : rising-edge clock, synchronous active-low reset
// s_data/s_valid  : upstream beat; s_ready is derived from the occupancy register only
// m_data/m_valid  : downstream beat, straight from registers; m_ready is the downstream accept
//
// The head entry is the output register. The spare entry only fills when the
// head is occupied, not popped, and a new beat arrives. A push and a pop in the
// same cycle leave the occupancy unchanged.
module axis_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [1:0]       count;
    logic [WIDTH-1:0] spare;
    logic             push;
    logic             pop;

    assign s_ready = (count != 2'd2);
    assign m_valid = (count != 2'd0);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= 2'd0;
            m_data <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        m_data <= s_data;
                        count  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        m_data <= s_data;
                    end else if (push) begin
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // s_ready is low here, so only a pop can happen
                    if (pop) begin
                        m_data <= spare;
                        count  <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (count == 2'd1 && push && !pop) begin
            spare <= s_data;
        end
    end

endmodule

// File: rtl/fir_decim_requant.sv
// Decimator and requantiser behind the 15-tap FIR.
//
// Keeps one Q2.30 sample in every DECIM (a tlast beat is always kept and
// restarts the group), rounds it half-up to Q1.15 with saturation, and presents
// it through a 2-entry skid buffer.
//
// clk, reset          : rising-edge clock, synchronous active-low reset
// s_axis_fir_*        : Q2.30 input stream (tkeep ignored)
// m_axis_dec_*        : Q1.15 output stream, registered
// sat_count           : number of kept samples that clamped, sticks at 0xFFFF
//
// A kept beat accepted on one edge is in stage A after that edge and on the
// output after the following edge.
module fir_decim_requant
    import dsp_pkg::*;
#(
    parameter int DECIM = 2,
    parameter int SHIFT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FIR_ACC_W-1:0] s_axis_fir_tdata,
    input  logic [3:0]           s_axis_fir_tkeep,
    input  logic                 s_axis_fir_tlast,
    input  logic                 s_axis_fir_tvalid,
    output logic                 s_axis_fir_tready,
    output logic [SAMPLE_W-1:0]  m_axis_dec_tdata,
    output logic [1:0]           m_axis_dec_tkeep,
    output logic                 m_axis_dec_tlast,
    output logic                 m_axis_dec_tvalid,
    input  logic                 m_axis_dec_tready,
    output logic [15:0]          sat_count
);

    localparam logic [3:0]                  LAST_PHASE = 4'(DECIM - 1);
    localparam logic signed [FIR_ACC_W:0]   ROUND_BIAS = 33'sd1 <<< (SHIFT - 1);

    // Add half an output LSB on a sign-extended copy so the bias never overflows,
    // then shift arithmetically: ties go toward +inf.
    function automatic logic signed [FIR_ACC_W:0] round_shift(input logic [FIR_ACC_W-1:0] x);
        logic signed [FIR_ACC_W:0] ext;
        ext = $signed({x[FIR_ACC_W-1], x});
        ext = ext + ROUND_BIAS;
        return ext >>> SHIFT;
    endfunction

    function automatic requant_t saturate(input logic signed [FIR_ACC_W:0] r);
        requant_t q;
        q.sat  = 1'b1;
        q.data = SAT_MAX;
        if (r > 33'sd32767) begin
            q.data = SAT_MAX;
        end else if (r < -33'sd32768) begin
            q.data = SAT_MIN;
        end else begin
            q.sat  = 1'b0;
            q.data = r[SAMPLE_W-1:0];
        end
        return q;
    endfunction

    logic                 run;
    logic [3:0]           phase;
    logic                 accept;
    logic                 keep;
    logic                 load_p1;
    requant_t             rq_p0;
    logic                 vld_p1;
    logic                 last_p1;
    logic [SAMPLE_W-1:0]  data_p1;
    logic                 skid_ready;
    logic                 skid_valid;
    logic [SAMPLE_W:0]    skid_data;
    logic                 unused_tkeep;

    assign unused_tkeep = ^s_axis_fir_tkeep;

    // run is low during reset so the input is not ready until the first edge out of reset.
    assign load_p1           = !vld_p1 || skid_ready;
    assign s_axis_fir_tready = run && load_p1;
    assign accept            = s_axis_fir_tvalid && s_axis_fir_tready;
    assign keep              = accept && ((phase == LAST_PHASE) || s_axis_fir_tlast);
    assign rq_p0             = saturate(round_shift(s_axis_fir_tdata));

    // ---- stage p0 -> stage A (p1) boundary ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            run       <= 1'b0;
            phase     <= 4'd0;
            vld_p1    <= 1'b0;
            sat_count <= 16'd0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (s_axis_fir_tlast || phase == LAST_PHASE) begin
                    phase <= 4'd0;
                end else begin
                    phase <= phase + 4'd1;
                end
            end
            // Dropped beats clear stage A as well, so they never wait on the output.
            if (load_p1) begin
                vld_p1 <= keep;
            end
            if (keep && rq_p0.sat && sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep) begin
            data_p1 <= rq_p0.data;
            last_p1 <= s_axis_fir_tlast;
        end
    end

    // ---- stage A -> skid buffer boundary ----
    axis_skid_buf #(
        .WIDTH(SAMPLE_W + 1)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_data  ({last_p1, data_p1}),
        .s_valid (vld_p1),
        .s_ready (skid_ready),
        .m_data  (skid_data),
        .m_valid (skid_valid),
        .m_ready (m_axis_dec_tready)
    );

    assign m_axis_dec_tdata  = skid_data[SAMPLE_W-1:0];
    assign m_axis_dec_tlast  = skid_data[SAMPLE_W];
    assign m_axis_dec_tvalid = skid_valid;
    assign m_axis_dec_tkeep  = {2{skid_valid}};

endmodule
